// File: rtl/cosine_controller.sv
// -----------------------------------------------------------------------------
// cosine_controller
//
// Control FSM sitting directly upstream of the cosine/distance datapath.
// Drives the datapath's encoded state bus, sequences the series evaluation
// from the datapath's stop/done flags, debounces the object-detect sensor,
// guards the series loop with a watchdog, and hands the finished distance
// to the consumer through a valid/ack handshake.
//
// State encoding (also the value driven on `state`):
//   0 StandBy, 1 Alert, 2 StartCalc, 3 Accumulate, 4 CalcDist,
//   5 Report, 7 Fault. Code 6 is unused and recovers to StandBy.
//
// Parameters:
//   ALERT_CYCLES  consecutive detect-high Alert cycles before a calculation
//                 starts (1..255)
//   TIMEOUT       maximum Accumulate cycles without stop before faulting
//                 (1..255)
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   detect        object-present sensor flag
//   stop          datapath flag: series term count reached
//   done          datapath flag: distance register loaded
//   ack           consumer has taken the result or the fault
//   state[2:0]    encoded state to the datapath (straight from the register)
//   busy          high in StartCalc, Accumulate, CalcDist and Report
//   result_valid  distance on the datapath output is valid
//   fault         watchdog expired
//
// Optional build macro: COSINE_CTRL_RETRIGGER_EN
//   When defined, an ack accepted in Report while detect is high moves
//   straight to Alert instead of StandBy, saving a cycle on back-to-back
//   targets. Fault always returns to StandBy.
// -----------------------------------------------------------------------------
module cosine_controller #(
  parameter int ALERT_CYCLES = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       detect,
  input  logic       stop,
  input  logic       done,
  input  logic       ack,
  output logic [2:0] state,
  output logic       busy,
  output logic       result_valid,
  output logic       fault
);

  typedef enum logic [2:0] {
    ST_STANDBY = 3'd0,
    ST_ALERT   = 3'd1,
    ST_START   = 3'd2,
    ST_ACCUM   = 3'd3,
    ST_CALC    = 3'd4,
    ST_REPORT  = 3'd5,
    ST_UNUSED  = 3'd6,
    ST_FAULT   = 3'd7
  } state_e;

  // Terminal counts for the shared counter; it starts at 0 on entry, so the
  // last allowed cycle sees count == N-1.
  localparam logic [7:0] ALERT_LAST   = 8'(ALERT_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cnt_inc;
  logic       busy_q, busy_d;
  logic       fault_q, fault_d;
  logic       accept;

  // result_valid qualifies the registered Report state with the live done
  // flag, so the consumer sees valid in the same cycle the distance lands.
  assign result_valid = (state_q == ST_REPORT) && done;
  assign accept       = result_valid && ack;

  // ---------------------------------------------------------------------------
  // Next-state, shared counter and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;

    case (state_q)
      ST_STANDBY: begin
        if (detect) state_d = ST_ALERT;
      end

      ST_ALERT: begin
        if (!detect)                 state_d = ST_STANDBY;
        else if (cnt_q == ALERT_LAST) state_d = ST_START;
        else                         cnt_inc = 1'b1;
      end

      ST_START: begin
        state_d = ST_ACCUM;
      end

      // stop is tested first so it wins over a simultaneous timeout.
      ST_ACCUM: begin
        if (stop)                       state_d = ST_CALC;
        else if (cnt_q == TIMEOUT_LAST) state_d = ST_FAULT;
        else                            cnt_inc = 1'b1;
      end

      ST_CALC: begin
        state_d = ST_REPORT;
      end

      // ack is only honoured while the result is actually valid.
      ST_REPORT: begin
        if (accept) begin
`ifdef COSINE_CTRL_RETRIGGER_EN
          state_d = detect ? ST_ALERT : ST_STANDBY;
`else
          state_d = ST_STANDBY;
`endif
        end
      end

      ST_FAULT: begin
        if (ack) state_d = ST_STANDBY;
      end

      default: begin
        state_d = ST_STANDBY;
      end
    endcase

    // One counter serves both the Alert debounce and the Accumulate
    // watchdog; any state change restarts it from zero.
    if (state_d != state_q) cnt_d = 8'd0;
    else if (cnt_inc)       cnt_d = cnt_q + 8'd1;
    else                    cnt_d = cnt_q;

    // Flag outputs are decoded from the next state so the registered copies
    // line up with the state register.
    busy_d  = (state_d == ST_START) || (state_d == ST_ACCUM) ||
              (state_d == ST_CALC)  || (state_d == ST_REPORT);
    fault_d = (state_d == ST_FAULT);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STANDBY;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign state = state_q;
  assign busy  = busy_q;
  assign fault = fault_q;

endmodule

// File: doc/cosine_controller.md
Name: cosine_controller

Overview:
- Control FSM directly upstream of the cosine/distance datapath.
- Drives the datapath's 3-bit state bus (0 StandBy, 1 Alert, 2 StartCalculation, 3 AccumulateTerms, 4 CalculateDistance).
- Sequences the datapath from its stop and done flags, debounces the object-detect input, and guards the series loop with a watchdog.
- Presents the finished distance to the consumer through a valid/ack handshake.

Parameters:
- ALERT_CYCLES, 4: consecutive detect-high cycles spent in Alert before a calculation starts; legal range 1..255.
- TIMEOUT, 16: maximum AccumulateTerms cycles without stop before the FSM faults; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- detect  input  1  object-present sensor flag.
- stop  input  1  datapath flag: series term count reached.
- done  input  1  datapath flag: distance register loaded.
- ack  input  1  consumer has taken the result or the fault.
- state  output  3  encoded state to the datapath.
- busy  output  1  high in states 2, 3, 4 and 5.
- result_valid  output  1  distance on the datapath output is valid.
- fault  output  1  watchdog expired.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst and has priority over every transition.
- Reset values: state=0, all internal counters=0, busy=0, result_valid=0, fault=0. Reset asserted mid-calculation returns to StandBy on the next edge; no partial result is reported.
- Encoding: 0 StandBy, 1 Alert, 2 StartCalc, 3 Accumulate, 4 CalcDist, 5 Report, 7 Fault. Code 6 is unused and goes to StandBy on the next edge.
- Outputs are registered state decodes; state is driven straight from the state register.
- Counters: one 8-bit counter, reused as the Alert debounce counter and the Accumulate watchdog counter. It clears on every state change.
- StandBy: detect=1 -> Alert; otherwise stay.
- Alert: detect=0 -> StandBy. With detect=1 the counter increments each cycle. When count==ALERT_CYCLES-1 and detect=1 -> StartCalc. Net effect: exactly ALERT_CYCLES consecutive Alert cycles with detect high are required.
- StartCalc: lasts exactly one cycle -> Accumulate. The datapath loads V, the expression (0) and the term (1.0) during this cycle.
- Accumulate: stop=1 -> CalcDist. Otherwise the counter increments. When count==TIMEOUT-1 and stop=0 -> Fault. If stop=1 on the same cycle as the timeout, stop wins.
- CalcDist: lasts exactly one cycle -> Report.
- Report: result_valid = (state==5) & done.
  - ack is honoured only while result_valid=1; the FSM then goes to StandBy on that edge.
  - ack while done=0 is ignored.
  - result_valid falls in the cycle after the accepting edge.
- Fault: fault=1. ack=1 -> StandBy. The datapath is idle in this state because no datapath state code is decoded.
- detect is ignored in states 2, 3, 4, 5 and 7; there is no mid-calculation abort.
- Nominal latency with stop arriving on the 9th Accumulate cycle: detect rise to result_valid = ALERT_CYCLES + 1 + 9 + 1 + 1 cycles, plus the datapath done settle.

Optional Feature:
- Macro: COSINE_CTRL_RETRIGGER_EN.
- Defined: in Report, if the ack is accepted while detect=1, the next state is Alert (counter cleared) instead of StandBy. This saves one cycle on back-to-back targets.
- Undefined: Report always returns to StandBy on an accepted ack.
- Fault always returns to StandBy in both builds.

Test Plan:
- Reset then detect high for 4 cycles (ALERT_CYCLES=4) -> state sequence 0,1,1,1,1,2,3; busy rises with state 2.
- Detect high 3 cycles then low 1 cycle -> state returns 0 with no StartCalc. Detect high 4 more cycles -> state 2 reached.
- Full run, stop asserted on the 9th Accumulate cycle, done high after CalcDist -> states 3 (x9), 4, 5. result_valid=1 once done=1. ack -> state 0 the next cycle and result_valid=0.
- In Report hold done=0 and pulse ack -> remains 5. Then done=1 with ack held high for 1 cycle -> state 0.
- stop held low in Accumulate (TIMEOUT=16) -> state 7 after 16 Accumulate cycles, fault=1. ack -> state 0, fault=0. A second run with stop=1 on cycle 16 goes to state 4, not 7.
- rst pulsed during Accumulate -> next edge state=0 and all outputs 0. Retrigger build: ack with detect=1 in Report -> state 1.
